// File: rtl/branch_predictor_bht.sv
// branch_predictor_bht
//   Direction predictor for beq/bne in a 5-stage MIPS pipeline. The IF stage
//   looks up a table of 2-bit saturating counters indexed by pc[INDEX_BITS+1:2].
//   The ID stage resolves the branch with the comparator's decision. It updates
//   the counter, and when the decision disagrees with the prediction carried
//   down the pipe it redirects the PC and flushes IF/ID.
// Ports
//   i_clk, i_reset              clock, synchronous active-high reset
//   i_if_valid/_is_branch       IF instruction valid / is a beq|bne
//   i_if_pc, i_if_target        IF PC and branch target
//   o_predict_taken/_pc         IF prediction and predicted next PC (comb)
//   i_id_stall                  ID held; no resolve, no IF capture
//   i_id_branch_valid/_taken    ID branch present / resolved direction
//   i_id_target, i_id_pc_plus4  ID taken target / fall-through PC
//   o_redirect_valid/_pc        misprediction redirect (comb)
//   o_branch_count              resolved branches, saturating
//   o_mispredict_count          mispredictions, saturating
module branch_predictor_bht #(
  parameter int INDEX_BITS = 6,
  parameter int PC_WIDTH   = 32
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_if_valid,
  input  logic                i_if_is_branch,
  input  logic [PC_WIDTH-1:0] i_if_pc,
  input  logic [PC_WIDTH-1:0] i_if_target,
  output logic                o_predict_taken,
  output logic [PC_WIDTH-1:0] o_predict_pc,
  input  logic                i_id_stall,
  input  logic                i_id_branch_valid,
  input  logic                i_id_branch_taken,
  input  logic [PC_WIDTH-1:0] i_id_target,
  input  logic [PC_WIDTH-1:0] i_id_pc_plus4,
  output logic                o_redirect_valid,
  output logic [PC_WIDTH-1:0] o_redirect_pc,
  output logic [15:0]         o_branch_count,
  output logic [15:0]         o_mispredict_count
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [1:0]            r_ctr [ENTRIES];
  logic                  r_pvalid;
  logic                  r_ptaken;
  logic [INDEX_BITS-1:0] r_pidx;
  logic [15:0]           r_branch_cnt;
  logic [15:0]           r_mispred_cnt;

  logic [INDEX_BITS-1:0] w_if_idx;
  logic [PC_WIDTH-1:0]   w_id_pc;
  logic [INDEX_BITS-1:0] w_upd_idx;
  logic [1:0]            w_upd_ctr;
  logic [1:0]            w_upd_next;
  logic                  w_resolve;
  logic                  w_pred_used;
  logic                  w_if_fire;
  logic                  w_unused_bits;

  // IF lookup reads the registered table, so an update landing at the same
  // edge is seen by the following cycle (read-before-write).
  assign w_if_idx        = i_if_pc[INDEX_BITS+1:2];
  assign o_predict_taken = i_if_valid & i_if_is_branch & r_ctr[w_if_idx][1];
  assign o_predict_pc    = o_predict_taken ? i_if_target : i_if_pc + PC_WIDTH'(4);

  // Without a carried prediction, the branch PC is recovered from the
  // fall-through PC to find its table entry.
  assign w_id_pc       = i_id_pc_plus4 - PC_WIDTH'(4);
  assign w_upd_idx     = r_pvalid ? r_pidx : w_id_pc[INDEX_BITS+1:2];
  assign w_unused_bits = ^{w_id_pc[1:0], w_id_pc[PC_WIDTH-1:INDEX_BITS+2]};

  assign w_resolve        = i_id_branch_valid & ~i_id_stall & ~i_reset;
  assign w_pred_used      = r_pvalid & r_ptaken;
  assign o_redirect_valid = w_resolve & (i_id_branch_taken != w_pred_used);
  assign o_redirect_pc    = i_id_branch_taken ? i_id_target : i_id_pc_plus4;

  assign w_if_fire = i_if_valid & ~i_id_stall & ~o_redirect_valid;

  assign w_upd_ctr  = r_ctr[w_upd_idx];
  always_comb begin
    w_upd_next = w_upd_ctr;
    if (i_id_branch_taken) begin
      if (w_upd_ctr != 2'b11) w_upd_next = w_upd_ctr + 2'b01;
    end else begin
      if (w_upd_ctr != 2'b00) w_upd_next = w_upd_ctr - 2'b01;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < ENTRIES; i++) r_ctr[i] <= 2'b01;
    end else if (w_resolve) begin
      r_ctr[w_upd_idx] <= w_upd_next;
    end
  end

  // Pending slot: prediction travelling alongside the IF/ID register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pvalid <= 1'b0;
      r_ptaken <= 1'b0;
      r_pidx   <= '0;
    end else if (o_redirect_valid) begin
      r_pvalid <= 1'b0;
    end else if (!i_id_stall) begin
      r_pvalid <= w_if_fire;
      if (w_if_fire) begin
        r_ptaken <= o_predict_taken;
        r_pidx   <= w_if_idx;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else begin
      if (w_resolve && r_branch_cnt != 16'hFFFF)
        r_branch_cnt <= r_branch_cnt + 16'd1;
      if (o_redirect_valid && r_mispred_cnt != 16'hFFFF)
        r_mispred_cnt <= r_mispred_cnt + 16'd1;
    end
  end

  assign o_branch_count     = r_branch_cnt;
  assign o_mispredict_count = r_mispred_cnt;

endmodule

// File: tb/tb_branch_predictor_bht.sv
module tb_branch_predictor_bht;
  logic        clk = 1'b0;
  logic        reset, if_valid, if_is_branch, id_stall, id_bv, id_taken;
  logic [31:0] if_pc, if_target, id_target, id_pc4;
  logic        predict_taken, redirect_valid;
  logic [31:0] predict_pc, redirect_pc;
  logic [15:0] branch_count, mispredict_count;

  int checks = 0;
  int errors = 0;

  // reference state: plain integers, saturation by min/max
  int        mctr [64];
  bit        mpv, mpt;
  int        mpidx;
  int        mbc, mmc;
  bit        e_pt, e_rv, e_res;
  logic [31:0] e_ppc, e_rpc;
  int        e_idx;

  always #5 clk = ~clk;

  branch_predictor_bht dut (
    .i_clk(clk), .i_reset(reset),
    .i_if_valid(if_valid), .i_if_is_branch(if_is_branch),
    .i_if_pc(if_pc), .i_if_target(if_target),
    .o_predict_taken(predict_taken), .o_predict_pc(predict_pc),
    .i_id_stall(id_stall), .i_id_branch_valid(id_bv),
    .i_id_branch_taken(id_taken), .i_id_target(id_target),
    .i_id_pc_plus4(id_pc4),
    .o_redirect_valid(redirect_valid), .o_redirect_pc(redirect_pc),
    .o_branch_count(branch_count), .o_mispredict_count(mispredict_count)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_eval();
    int used;
    e_idx = int'(if_pc[31:2] % 64);
    e_pt  = if_valid && if_is_branch && (mctr[e_idx] >= 2);
    e_ppc = e_pt ? if_target : if_pc + 32'd4;
    e_res = id_bv && !id_stall && !reset;
    used  = mpv ? int'(mpt) : 0;
    e_rv  = e_res && (int'(id_taken) != used);
    e_rpc = id_taken ? id_target : id_pc4;
  endtask

  task automatic model_update();
    logic [31:0] bpc;
    int ui;
    if (reset) begin
      foreach (mctr[i]) mctr[i] = 1;
      mpv = 0; mpt = 0; mpidx = 0; mbc = 0; mmc = 0;
      return;
    end
    if (e_res) begin
      bpc = id_pc4 - 32'd4;
      ui  = mpv ? mpidx : int'(bpc[31:2] % 64);
      mctr[ui] = id_taken ? ((mctr[ui] + 1 > 3) ? 3 : mctr[ui] + 1)
                          : ((mctr[ui] - 1 < 0) ? 0 : mctr[ui] - 1);
      mbc = (mbc == 65535) ? 65535 : mbc + 1;
      if (e_rv) mmc = (mmc == 65535) ? 65535 : mmc + 1;
    end
    if (e_rv) mpv = 0;
    else if (!id_stall) begin
      if (if_valid) begin mpv = 1; mpt = e_pt; mpidx = e_idx; end
      else mpv = 0;
    end
  endtask

  // per-cycle compare against the model, then advance one clock
  task automatic tick();
    #1;
    model_eval();
    check("predict_taken", {31'd0, predict_taken}, {31'd0, e_pt});
    check("predict_pc", predict_pc, e_ppc);
    check("redirect_valid", {31'd0, redirect_valid}, {31'd0, e_rv});
    check("redirect_pc", redirect_pc, e_rpc);
    check("branch_count", {16'd0, branch_count}, mbc[31:0]);
    check("mispredict_count", {16'd0, mispredict_count}, mmc[31:0]);
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    if_valid = 0; if_is_branch = 0; id_stall = 0; id_bv = 0; id_taken = 0;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] tgt);
    if_valid = 1; if_is_branch = 1; if_pc = pc; if_target = tgt;
  endtask

  task automatic resolve(input bit tk, input logic [31:0] tgt, input logic [31:0] pc4);
    id_bv = 1; id_taken = tk; id_target = tgt; id_pc4 = pc4;
  endtask

  initial begin
    foreach (mctr[i]) mctr[i] = 0;
    mpv = 0; mpt = 0; mpidx = 0; mbc = 0; mmc = 0;
    reset = 1; idle();
    if_pc = 0; if_target = 0; id_target = 0; id_pc4 = 0;
    tick(); tick();
    #1;
    check("rst redirect_valid", {31'd0, redirect_valid}, 32'd0);
    check("rst branch_count", {16'd0, branch_count}, 32'd0);
    reset = 0;

    // first encounter, weak not-taken, resolves taken
    fetch(32'h00400010, 32'h00400040);
    #1;
    check("t1 predict_taken", {31'd0, predict_taken}, 32'd0);
    check("t1 predict_pc", predict_pc, 32'h00400014);
    tick();
    idle(); resolve(1, 32'h00400040, 32'h00400014);
    #1;
    check("t1 redirect_valid", {31'd0, redirect_valid}, 32'd1);
    check("t1 redirect_pc", redirect_pc, 32'h00400040);
    tick();

    // trained to 2: predicts taken, then saturates at 3
    idle(); fetch(32'h00400010, 32'h00400040);
    #1;
    check("t2 predict_taken", {31'd0, predict_taken}, 32'd1);
    check("t2 predict_pc", predict_pc, 32'h00400040);
    tick();
    resolve(1, 32'h00400040, 32'h00400014);
    #1;
    check("t2 no redirect a", {31'd0, redirect_valid}, 32'd0);
    tick();
    idle(); resolve(1, 32'h00400040, 32'h00400014);
    #1;
    check("t2 no redirect b", {31'd0, redirect_valid}, 32'd0);
    tick();

    // strongly taken, resolves not-taken
    idle(); fetch(32'h00400010, 32'h00400040);
    tick();
    idle(); resolve(0, 32'h00400040, 32'h00400014);
    #1;
    check("t3 redirect_valid", {31'd0, redirect_valid}, 32'd1);
    check("t3 redirect_pc", redirect_pc, 32'h00400014);
    tick();
    idle(); fetch(32'h00400010, 32'h00400040);
    #1;
    check("t3 mispredict_count", {16'd0, mispredict_count}, 32'd2);
    check("t3 ctr4 still taken", {31'd0, predict_taken}, 32'd1);
    tick();

    // stall holds a taken-mispredicting branch at index 0
    idle(); resolve(1, 32'h00400040, 32'h00400014);
    fetch(32'h00400100, 32'h00400200);
    #1;
    check("t4 fetch pred", {31'd0, predict_taken}, 32'd0);
    tick();
    resolve(1, 32'h00400200, 32'h00400104);
    id_stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t4 stall no redirect", {31'd0, redirect_valid}, 32'd0);
      tick();
    end
    id_stall = 0;
    #1;
    check("t4 redirect after stall", {31'd0, redirect_valid}, 32'd1);
    check("t4 redirect_pc", redirect_pc, 32'h00400200);
    tick();
    idle();
    #1;
    check("t4 branch_count", {16'd0, branch_count}, 32'd6);
    check("t4 mispredict_count", {16'd0, mispredict_count}, 32'd3);

    // read-before-write on index 0 (ctr0 = 2)
    fetch(32'h00400100, 32'h00400200);
    tick();
    idle(); resolve(0, 32'h00400200, 32'h00400104);
    fetch(32'h00400100, 32'h00400200);
    #1;
    check("t5 old value", {31'd0, predict_taken}, 32'd1);
    tick();
    idle(); fetch(32'h00400100, 32'h00400200);
    #1;
    check("t5 new value", {31'd0, predict_taken}, 32'd0);
    tick();

    // reset with a pending taken prediction and ctr4 = 3
    idle(); fetch(32'h00400010, 32'h00400040);
    tick();
    idle(); reset = 1; resolve(0, 32'h00400040, 32'h00400014);
    #1;
    check("t6 redirect in reset", {31'd0, redirect_valid}, 32'd0);
    tick();
    reset = 0; idle(); fetch(32'h00400010, 32'h00400040);
    #1;
    check("t6 ctr4 reset", {31'd0, predict_taken}, 32'd0);
    check("t6 stats cleared", {16'd0, branch_count}, 32'd0);
    tick();
    idle(); resolve(1, 32'h00400040, 32'h00400014);
    #1;
    check("t6 redirect after reset", {31'd0, redirect_valid}, 32'd1);
    tick();

    // randomized traffic on a small PC window to force aliasing/training
    for (int n = 0; n < 3000; n++) begin
      reset        = ($urandom_range(0, 255) == 0);
      if_valid     = ($urandom_range(0, 3) != 0);
      if_is_branch = ($urandom_range(0, 2) != 0);
      if_pc        = ($urandom_range(0, 63) == 0) ? 32'hFFFFFFFC
                     : 32'h00400000 + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
      if_target    = $urandom;
      id_stall     = ($urandom_range(0, 3) == 0);
      id_bv        = ($urandom_range(0, 1) == 1);
      id_taken     = ($urandom_range(0, 1) == 1);
      id_target    = $urandom;
      id_pc4       = ($urandom_range(0, 63) == 0) ? 32'h0
                     : 32'h00400004 + ($urandom_range(0, 15) << 2);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
